// File: rtl/tpu_pkg.sv
// Shared constants, feeder FSM states and lane slicing helper
// for the systolic array input path.
package tpu_pkg;

  localparam int DATA_SIZE = 8;
  localparam int MAC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feed_state_e;

  function automatic int lane_lsb(input int lane, input int dsize);
    return lane * dsize;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO holding {last, row} entries ahead of the skew
// pipeline; no bypass, so a write is readable one edge later.
module feeder_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  assign wr_ready_o = count_q < CW'(DEPTH);
  assign empty_o    = count_q == '0;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_en_i && !empty_o;
  assign rd_data_o  = mem_q[rptr_q];
  assign count_o    = count_q;

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/systolic_feeder.sv
// West-edge feeder: buffers activation rows, skews lane i by i
// cycles and flushes the array tail with zero vectors per tile.
module systolic_feeder #(
  parameter int DATA_SIZE = tpu_pkg::DATA_SIZE,
  parameter int MAC_WIDTH = tpu_pkg::MAC_WIDTH,
  parameter int DEPTH     = 16,
  localparam int VW = MAC_WIDTH * DATA_SIZE,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VW-1:0]        in_data,
  input  logic                 in_last,
  input  logic                 clear_err,
  output logic [2*VW-1:0]      values_out,
  output logic [MAC_WIDTH-1:0] lane_valid,
  output logic                 tile_done,
  output logic                 busy,
  output logic                 underflow,
  output logic [CW-1:0]        fifo_count
);

  import tpu_pkg::*;

  localparam int FW = (MAC_WIDTH > 2) ? $clog2(MAC_WIDTH - 1) : 1;
  localparam logic [FW-1:0] FLUSH_INIT = FW'(MAC_WIDTH - 2);
  localparam feed_state_e LAST_NEXT =
    (MAC_WIDTH == 1) ? DONE : FLUSH;

  feed_state_e   state_q;
  logic [FW-1:0] flush_q;
  logic          underflow_q;
  logic [VW:0]   head;
  logic          fifo_empty;
  logic          pop;

  feeder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (VW + 1)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  ({in_last, in_data}),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign pop = !fifo_empty &&
               (state_q == IDLE || state_q == STREAM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      flush_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (clear_err) underflow_q <= 1'b0;
      unique case (state_q)
        IDLE, STREAM: begin
          if (pop) begin
            if (head[VW]) begin
              state_q <= LAST_NEXT;
              flush_q <= FLUSH_INIT;
            end else begin
              state_q <= STREAM;
            end
          end else if (state_q == STREAM) begin
            // a starved stream keeps skewing zeros; set wins over clear
            underflow_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_q == '0) state_q <= DONE;
          else               flush_q <= flush_q - 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tile_done = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign underflow = underflow_q;

  assign values_out[2*VW-1:VW] = '0;

  for (genvar i = 0; i < MAC_WIDTH; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, DATA_SIZE);

    logic [i:0][DATA_SIZE-1:0] dat_q;
    logic [i:0]                vld_q;
    logic [DATA_SIZE-1:0]      inj;

    assign inj = pop ? head[LSB +: DATA_SIZE] : '0;

    if (i == 0) begin : g_head
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          dat_q <= '0;
          vld_q <= '0;
        end else begin
          dat_q <= inj;
          vld_q <= pop;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          dat_q <= '0;
          vld_q <= '0;
        end else begin
          dat_q <= {dat_q[i-1:0], inj};
          vld_q <= {vld_q[i-1:0], pop};
        end
      end
    end

    assign values_out[LSB +: DATA_SIZE] = dat_q[i];
    assign lane_valid[i]                = vld_q[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a queue-based reference
// model compared every cycle plus hand-computed literal checks.
module tb_systolic_feeder;

  localparam int DS    = 8;
  localparam int MW    = 8;
  localparam int DEPTH = 16;
  localparam int VW    = MW * DS;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [VW-1:0]   in_data;
  logic            in_last;
  logic            clear_err;
  logic [2*VW-1:0] values_out;
  logic [MW-1:0]   lane_valid;
  logic            tile_done;
  logic            busy;
  logic            underflow;
  logic [CW-1:0]   fifo_count;

  systolic_feeder #(
    .DATA_SIZE (DS),
    .MAC_WIDTH (MW),
    .DEPTH     (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .clear_err  (clear_err),
    .values_out (values_out),
    .lane_valid (lane_valid),
    .tile_done  (tile_done),
    .busy       (busy),
    .underflow  (underflow),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          last;
    logic [VW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic [VW-1:0] hd [MW];
  bit            hv [MW];
  int            blocked = 0;
  bit            in_tile = 0;
  bit            uf      = 0;
  int            edge_n  = 0;
  ent_t          e;
  bit            can_push;
  bit            do_pop;
  bit            set_uf;
  logic [VW-1:0] inj;

  // after a last row no further row may enter for MW edges
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      blocked = 0;
      in_tile = 0;
      uf      = 0;
      for (int i = 0; i < MW; i++) begin
        hd[i] = '0;
        hv[i] = 0;
      end
    end else begin
      edge_n++;
      can_push = q.size() < DEPTH;
      do_pop   = 0;
      set_uf   = 0;
      inj      = '0;
      if (blocked > 0) begin
        blocked--;
      end else if (q.size() > 0) begin
        e      = q.pop_front();
        do_pop = 1;
        inj    = e.data;
        if (e.last) begin
          blocked = MW;
          in_tile = 0;
        end else begin
          in_tile = 1;
        end
      end else if (in_tile) begin
        set_uf = 1;
      end
      if (clear_err) uf = 0;
      if (set_uf)    uf = 1;
      if (in_valid && can_push) q.push_back({in_last, in_data});
      for (int i = MW - 1; i > 0; i--) begin
        hd[i] = hd[i-1];
        hv[i] = hv[i-1];
      end
      hd[0] = inj;
      hv[0] = do_pop;
    end
  end

  logic [VW-1:0] ev;
  logic [MW-1:0] elv;

  always @(negedge clock) begin
    for (int i = 0; i < MW; i++) begin
      ev[i*DS +: DS] = hd[i][i*DS +: DS];
      elv[i]         = hv[i];
    end
    check("values", values_out[VW-1:0], ev);
    check("upper_zero", values_out[2*VW-1:VW], '0);
    check("lane_valid", lane_valid, elv);
    check("tile_done", tile_done, blocked == 1);
    check("busy", busy, in_tile || blocked > 0);
    check("underflow", underflow, uf);
    check("in_ready", in_ready, q.size() < DEPTH);
    check("fifo_count", fifo_count, q.size());
  end

  int done_cnt = 0;
  always @(negedge clock) if (tile_done === 1'b1) done_cnt++;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_edge(input int n);
    for (int g = 0; g < 500 && edge_n < n; g++) tick();
    @(negedge clock);
    check("edge_reached", edge_n, n);
  endtask

  task automatic wait_idle();
    int g;
    for (g = 0; g < 600; g++) begin
      if (q.size() == 0 && !in_tile && blocked == 0) break;
      tick();
    end
    check("drain_timeout", g < 600, 1'b1);
    repeat (MW + 1) tick();
  endtask

  function automatic logic [VW-1:0] mk_row(input int r);
    logic [VW-1:0] v;
    for (int i = 0; i < MW; i++) v[i*DS +: DS] = DS'(r * 16 + i);
    return v;
  endfunction

  int E;
  int p;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    clear_err = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("rst_values", values_out, '0);
    check("rst_lane_valid", lane_valid, '0);
    check("rst_tile_done", tile_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", fifo_count, '0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // single tile of three rows
    E = edge_n;
    in_valid = 1'b1;
    in_data  = mk_row(0);
    tick();
    in_data = mk_row(1);
    tick();
    in_data = mk_row(2);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    p = E + 2;
    at_edge(p + 5);
    check("lane5_row0", values_out[5*DS +: DS], 8'h05);
    check("lane5_valid", lane_valid[5], 1'b1);
    at_edge(p + 6);
    check("lane5_row1", values_out[5*DS +: DS], 8'h15);
    at_edge(p + 7);
    check("lane5_row2", values_out[5*DS +: DS], 8'h25);
    check("lane7_row0", values_out[7*DS +: DS], 8'h07);
    at_edge(p + 8);
    check("done_early", tile_done, 1'b0);
    check("lane5_flush", lane_valid[5], 1'b0);
    at_edge(p + 9);
    check("done_pulse", tile_done, 1'b1);
    check("lane7_last", values_out[7*DS +: DS], 8'h27);
    at_edge(p + 10);
    check("done_single", tile_done, 1'b0);
    wait_idle();

    // reset in the middle of a stream
    E = edge_n;
    in_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_data = mk_row(8 + r);
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("mid_rst_values", values_out, '0);
    check("mid_rst_valid", lane_valid, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_count", fifo_count, '0);
    check("mid_rst_ready", in_ready, 1'b1);
    tick();
    reset    = 1'b0;
    done_cnt = 0;
    repeat (20) tick();
    @(negedge clock);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_count_after", fifo_count, '0);

    // backpressure: single-row tiles fill the FIFO during flushes
    tick();
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      in_data = mk_row(t[3:0]) ^ {MW{8'h5a}};
      tick();
      if (t == 19) in_valid = 1'b0;
      if (t == 17) begin
        @(negedge clock);
        check("bp_full_count", fifo_count, 5'd16);
        check("bp_full_ready", in_ready, 1'b0);
      end
      if (t == 18) begin
        @(negedge clock);
        check("bp_17th_rejected", fifo_count, 5'd16);
      end
      if (t == 19) begin
        @(negedge clock);
        check("bp_pop_at_full", fifo_count, 5'd15);
        check("bp_ready_again", in_ready, 1'b1);
      end
    end
    in_last = 1'b0;
    wait_idle();

    // underflow and clear_err
    E = edge_n;
    in_valid = 1'b1;
    in_data  = mk_row(3);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clock);
    check("uf_pop_valid", lane_valid[0], 1'b1);
    check("uf_not_yet", underflow, 1'b0);
    tick();
    @(negedge clock);
    check("uf_set", underflow, 1'b1);
    check("uf_zero_lane0", lane_valid[0], 1'b0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clock);
    check("uf_set_beats_clear", underflow, 1'b1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = mk_row(9);
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clock);
    check("uf_cleared", underflow, 1'b0);
    check("uf_last_lane0", values_out[DS-1:0], 8'h90);
    at_edge(E + 13);
    check("uf_tile_done", tile_done, 1'b1);
    wait_idle();

    // back-to-back two-row tiles
    E = edge_n;
    in_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_data = mk_row(4 + r);
      in_last = r[0];
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    at_edge(E + 10);
    check("b2b_done_a", tile_done, 1'b1);
    at_edge(E + 11);
    check("b2b_gap_idle", lane_valid[0], 1'b0);
    at_edge(E + 12);
    check("b2b_second_pop", lane_valid[0], 1'b1);
    check("b2b_b0_lane0", values_out[DS-1:0], 8'h60);
    at_edge(E + 13);
    check("b2b_b1_lane0", values_out[DS-1:0], 8'h70);
    at_edge(E + 19);
    check("b2b_b0_lane7", values_out[7*DS +: DS], 8'h67);
    at_edge(E + 20);
    check("b2b_done_b", tile_done, 1'b1);
    check("b2b_b1_lane7", values_out[7*DS +: DS], 8'h77);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
